// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID pipeline register.
// Holds the occupancy-state enum, default widths and the default NOP encoding.
package if_id_pkg;

  localparam int IF_ID_INSTR_W = 16;
  localparam int IF_ID_ADDR_W  = 16;

  localparam logic [IF_ID_INSTR_W-1:0] IF_ID_NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IF_ID_EMPTY = 2'd0,
    IF_ID_ONE   = 2'd1,
    IF_ID_TWO   = 2'd2
  } if_id_state_e;

  // Number of held entries implied by a state.
  function automatic logic [1:0] if_id_occupancy(input if_id_state_e s);
    case (s)
      IF_ID_ONE: return 2'd1;
      IF_ID_TWO: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_slot.sv
// One instruction/address/valid holding register for the IF/ID stage.
// clear wipes the slot to a bubble with address 0; load writes a new
// {valid, instruction, address}. A load with valid=0 turns the slot into a
// bubble that keeps the supplied address, which is how the top keeps the
// last PC visible after the final entry drains.
module if_id_slot
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = IF_ID_INSTR_W,
  parameter int                 ADDR_W    = IF_ID_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instruction,
  input  logic [ADDR_W-1:0]  load_address,
  output logic               valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  address
);

  // Slot contents update on the falling edge; clear wins over load.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      instruction <= NOP_INSTR;
      address     <= '0;
    end else if (clear) begin
      valid       <= 1'b0;
      instruction <= NOP_INSTR;
      address     <= '0;
    end else if (load) begin
      valid       <= load_valid;
      instruction <= load_valid ? load_instruction : NOP_INSTR;
      address     <= load_address;
    end
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready handshake, stall and flush.
// Build option IF_ID_SKID_EN: adds a second (skid) slot and a registered
// out_ready so fetch can stream at full rate; without it the register holds a
// single entry and out_ready is derived combinationally from inp_ready.
// All state changes on the falling edge of inp_clk.
module if_id_stage_reg
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = IF_ID_INSTR_W,
  parameter int                 ADDR_W    = IF_ID_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               inp_clk,
  input  logic               inp_rst,
  input  logic               inp_valid,
  input  logic [INSTR_W-1:0] inp_instruction,
  input  logic [ADDR_W-1:0]  inp_address,
  output logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_address,
  input  logic               inp_ready,
  input  logic               inp_flush,
  output logic [1:0]         out_occupancy
);

  if_id_state_e state_q, state_d;

  logic               accept, deliver;
  logic               main_load, main_clear, main_d_valid;
  logic [INSTR_W-1:0] main_d_instr;
  logic [ADDR_W-1:0]  main_d_addr;

  assign accept  = inp_valid && out_ready;
  assign deliver = out_valid && inp_ready;

  if_id_slot #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk              (inp_clk),
    .rst              (inp_rst),
    .load             (main_load),
    .clear            (main_clear),
    .load_valid       (main_d_valid),
    .load_instruction (main_d_instr),
    .load_address     (main_d_addr),
    .valid            (out_valid),
    .instruction      (out_instruction),
    .address          (out_address)
  );

`ifdef IF_ID_SKID_EN
  logic               skid_load, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_addr;
  logic               ready_q;

  if_id_slot #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk              (inp_clk),
    .rst              (inp_rst),
    .load             (skid_load),
    .clear            (skid_clear),
    .load_valid       (1'b1),
    .load_instruction (inp_instruction),
    .load_address     (inp_address),
    .valid            (skid_valid),
    .instruction      (skid_instr),
    .address          (skid_addr)
  );

  // Registered ready: fetch may push whenever the next state leaves a free slot.
  always_ff @(negedge inp_clk or posedge inp_rst) begin
    if (inp_rst) ready_q <= 1'b1;
    else         ready_q <= (state_d != IF_ID_TWO);
  end

  assign out_ready = ready_q;
`else
  assign out_ready = !out_valid || inp_ready;
`endif

  // Occupancy state register.
  always_ff @(negedge inp_clk or posedge inp_rst) begin
    if (inp_rst) state_q <= IF_ID_EMPTY;
    else         state_q <= state_d;
  end

  // Next occupancy from this cycle's accept/deliver; flush overrides both.
  always_comb begin
    state_d = state_q;
    if (inp_flush) begin
      state_d = IF_ID_EMPTY;
    end else begin
      case (state_q)
        IF_ID_EMPTY: if (accept) state_d = IF_ID_ONE;
        IF_ID_ONE: begin
`ifdef IF_ID_SKID_EN
          if (accept && !deliver) state_d = IF_ID_TWO;
`endif
          if (deliver && !accept) state_d = IF_ID_EMPTY;
        end
`ifdef IF_ID_SKID_EN
        IF_ID_TWO: if (deliver) state_d = IF_ID_ONE;
`endif
        default: state_d = IF_ID_EMPTY;
      endcase
    end
  end

  // Slot load/clear selects for the current state and handshake.
  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    main_d_valid = 1'b0;
    main_d_instr = inp_instruction;
    main_d_addr  = inp_address;
`ifdef IF_ID_SKID_EN
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
`endif
    if (inp_flush) begin
      main_clear = 1'b1;
`ifdef IF_ID_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        IF_ID_EMPTY: begin
          if (accept) begin
            main_load    = 1'b1;
            main_d_valid = 1'b1;
          end
        end
        IF_ID_ONE: begin
          if (accept && deliver) begin
            main_load    = 1'b1;
            main_d_valid = 1'b1;
`ifdef IF_ID_SKID_EN
          end else if (accept) begin
            skid_load = 1'b1;
`endif
          end else if (deliver) begin
            main_load    = 1'b1;
            main_d_valid = 1'b0;
            main_d_addr  = out_address;
          end
        end
`ifdef IF_ID_SKID_EN
        IF_ID_TWO: begin
          if (deliver) begin
            main_load    = 1'b1;
            main_d_valid = skid_valid;
            main_d_instr = skid_instr;
            main_d_addr  = skid_addr;
            skid_clear   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_occupancy = if_id_occupancy(state_q);

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Testbench for if_id_stage_reg: table-driven directed vectors plus
// hand-written sequences for async reset and the out_ready path.
// Expectations follow the IF_ID_SKID_EN build option.
module tb_if_id_stage_reg;

  logic        inp_clk;
  logic        inp_rst;
  logic        inp_valid;
  logic [15:0] inp_instruction;
  logic [15:0] inp_address;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_address;
  logic        inp_ready;
  logic        inp_flush;
  logic [1:0]  out_occupancy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [15:0] addr;
    logic        rdy;
    logic        fl;
    logic        exp_v;
    logic [15:0] exp_instr;
    logic [15:0] exp_addr;
    logic        exp_or;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs[$];

  if_id_stage_reg dut (
    .inp_clk         (inp_clk),
    .inp_rst         (inp_rst),
    .inp_valid       (inp_valid),
    .inp_instruction (inp_instruction),
    .inp_address     (inp_address),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_address     (out_address),
    .inp_ready       (inp_ready),
    .inp_flush       (inp_flush),
    .out_occupancy   (out_occupancy)
  );

  // Free-running clock; active edge is the falling edge.
  initial begin
    inp_clk = 1'b1;
    forever #5 inp_clk = ~inp_clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic [15:0] instr, input logic [15:0] addr,
                              input logic rdy, input logic fl, input logic ev,
                              input logic [15:0] ei, input logic [15:0] ea,
                              input logic eor, input logic [1:0] eocc);
    vec_t r;
    r.v = v; r.instr = instr; r.addr = addr; r.rdy = rdy; r.fl = fl;
    r.exp_v = ev; r.exp_instr = ei; r.exp_addr = ea; r.exp_or = eor; r.exp_occ = eocc;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t vec);
    @(posedge inp_clk);
    #1;
    inp_valid       = vec.v;
    inp_instruction = vec.instr;
    inp_address     = vec.addr;
    inp_ready       = vec.rdy;
    inp_flush       = vec.fl;
    @(negedge inp_clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [15:0] ei,
                             input logic [15:0] ea, input logic eor, input logic [1:0] eocc);
    checkOne({name, ".out_valid"},       {15'd0, out_valid},     {15'd0, ev});
    checkOne({name, ".out_instruction"}, out_instruction,        ei);
    checkOne({name, ".out_address"},     out_address,            ea);
    checkOne({name, ".out_ready"},       {15'd0, out_ready},     {15'd0, eor});
    checkOne({name, ".out_occupancy"},   {14'd0, out_occupancy}, {14'd0, eocc});
  endtask

  initial begin
    inp_rst = 1'b1;
    inp_valid = 1'b0; inp_instruction = '0; inp_address = '0;
    inp_ready = 1'b0; inp_flush = 1'b0;

    //             v  instr     addr      rdy fl   ev ei        ea        or occ
    // Idle after reset release, then a full-rate stream.
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 1, 2'd0));
    vecs.push_back(mk(1, 16'h1111, 16'h0000, 1, 0,  1, 16'h1111, 16'h0000, 1, 2'd1));
    vecs.push_back(mk(1, 16'h2222, 16'h0002, 1, 0,  1, 16'h2222, 16'h0002, 1, 2'd1));
    vecs.push_back(mk(1, 16'h3333, 16'h0004, 1, 0,  1, 16'h3333, 16'h0004, 1, 2'd1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0004, 1, 2'd0));
`ifdef IF_ID_SKID_EN
    // Stall fills both slots, then drains in order.
    vecs.push_back(mk(1, 16'hAAAA, 16'h0010, 0, 0,  1, 16'hAAAA, 16'h0010, 1, 2'd1));
    vecs.push_back(mk(1, 16'hBBBB, 16'h0012, 0, 0,  1, 16'hAAAA, 16'h0010, 0, 2'd2));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0,  1, 16'hAAAA, 16'h0010, 0, 2'd2));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  1, 16'hBBBB, 16'h0012, 1, 2'd1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0012, 1, 2'd0));
    // Flush while full with a new instruction offered.
    vecs.push_back(mk(1, 16'h4444, 16'h0020, 0, 0,  1, 16'h4444, 16'h0020, 1, 2'd1));
    vecs.push_back(mk(1, 16'h5555, 16'h0022, 0, 0,  1, 16'h4444, 16'h0020, 0, 2'd2));
    vecs.push_back(mk(1, 16'hCCCC, 16'h0024, 0, 1,  0, 16'h0000, 16'h0000, 1, 2'd0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 1, 2'd0));
    // Flush discards a simultaneous accept and deliver.
    vecs.push_back(mk(1, 16'h6666, 16'h0030, 0, 0,  1, 16'h6666, 16'h0030, 1, 2'd1));
    vecs.push_back(mk(1, 16'h7777, 16'h0032, 1, 1,  0, 16'h0000, 16'h0000, 1, 2'd0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 1, 2'd0));
`else
    // Stall: second instruction refused until decode takes the first.
    vecs.push_back(mk(1, 16'hAAAA, 16'h0010, 0, 0,  1, 16'hAAAA, 16'h0010, 0, 2'd1));
    vecs.push_back(mk(1, 16'hBBBB, 16'h0012, 0, 0,  1, 16'hAAAA, 16'h0010, 0, 2'd1));
    vecs.push_back(mk(1, 16'hBBBB, 16'h0012, 1, 0,  1, 16'hBBBB, 16'h0012, 1, 2'd1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0012, 1, 2'd0));
    // Flush while holding with a new instruction offered.
    vecs.push_back(mk(1, 16'h4444, 16'h0020, 0, 0,  1, 16'h4444, 16'h0020, 0, 2'd1));
    vecs.push_back(mk(1, 16'h5555, 16'h0022, 0, 0,  1, 16'h4444, 16'h0020, 0, 2'd1));
    vecs.push_back(mk(1, 16'hCCCC, 16'h0024, 0, 1,  0, 16'h0000, 16'h0000, 1, 2'd0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 1, 2'd0));
    // Flush discards a simultaneous accept and deliver.
    vecs.push_back(mk(1, 16'h6666, 16'h0030, 0, 0,  1, 16'h6666, 16'h0030, 0, 2'd1));
    vecs.push_back(mk(1, 16'h7777, 16'h0032, 1, 1,  0, 16'h0000, 16'h0000, 1, 2'd0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 1, 2'd0));
`endif

    // Reset state while reset is held.
    repeat (2) @(negedge inp_clk);
    #1;
    checkOutput("reset", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
    @(posedge inp_clk);
    #1;
    inp_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_instr,
                  vecs[i].exp_addr, vecs[i].exp_or, vecs[i].exp_occ);
    end

    // Fill, then pulse async reset between edges.
    applyStimulus(mk(1, 16'h8888, 16'h0040, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 16'h9999, 16'h0042, 0, 0, 0, 0, 0, 0, 0));
`ifdef IF_ID_SKID_EN
    checkOutput("prefill", 1'b1, 16'h8888, 16'h0040, 1'b0, 2'd2);
`else
    checkOutput("prefill", 1'b1, 16'h8888, 16'h0040, 1'b0, 2'd1);
`endif
    @(posedge inp_clk);
    #1;
    inp_valid = 1'b0;
    #1;
    inp_rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0);
    #1;
    inp_rst = 1'b0;
    inp_valid = 1'b1; inp_instruction = 16'hABCD; inp_address = 16'h0050;
    @(negedge inp_clk);
    #1;
`ifdef IF_ID_SKID_EN
    checkOutput("post_rst_accept", 1'b1, 16'hABCD, 16'h0050, 1'b1, 2'd1);
`else
    checkOutput("post_rst_accept", 1'b1, 16'hABCD, 16'h0050, 1'b0, 2'd1);
`endif

    // Toggle inp_ready between edges with one entry held.
    @(posedge inp_clk);
    #1;
    inp_valid = 1'b0;
    inp_ready = 1'b1;
    #1;
    checkOne("ready_path_hi", {15'd0, out_ready}, 16'd1);
    inp_ready = 1'b0;
    #1;
`ifdef IF_ID_SKID_EN
    checkOne("ready_path_lo", {15'd0, out_ready}, 16'd1);
`else
    checkOne("ready_path_lo", {15'd0, out_ready}, 16'd0);
`endif
    @(negedge inp_clk);
    #1;
    checkOutput("ready_path_hold", 1'b1, 16'hABCD, 16'h0050, out_ready, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_id_stage_reg.md
# if_id_stage_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, stall, flush and an optional two-entry skid buffer. It sits between the fetch stage (instruction memory / cache) and the decode stage. It replaces the fixed 16-bit hit-gated latch with a register that:

- holds an instruction/PC pair until decode accepts it,
- can be squashed on a taken branch,
- runs at full throughput with a registered upstream ready.

## Interface

Parameters:
- INSTR_W, 16, instruction width in bits
- ADDR_W, 16, PC/address width in bits
- NOP_INSTR, {INSTR_W{1'b0}}, value driven on out_instruction whenever no valid entry is presented

Ports:
- inp_clk  in  1  clock; all state updates on the falling edge
- inp_rst  in  1  reset, asynchronous, active-high
- inp_valid  in  1  fetch presents an instruction (cache hit)
- inp_instruction  in  INSTR_W  fetched instruction
- inp_address  in  ADDR_W  PC of fetched instruction
- out_ready  out  1  register can accept from fetch this cycle
- out_valid  out  1  out_instruction/out_address hold a live entry
- out_instruction  out  INSTR_W  instruction to decode
- out_address  out  ADDR_W  PC to decode
- inp_ready  in  1  decode consumes the presented entry
- inp_flush  in  1  squash all held entries (taken branch/jump)
- out_occupancy  out  2  number of held entries (0..2)

## Operation

- Accept: inp_valid && out_ready at a falling edge.
- Deliver: out_valid && inp_ready at a falling edge.
- Entries are in-order. The main slot drives the outputs. The skid slot holds the second entry.
- States follow occupancy: EMPTY, ONE, TWO.
  - EMPTY, accept → ONE. The new entry goes to main.
  - ONE, accept and no deliver → TWO. The new entry goes to skid.
  - ONE, accept and deliver → ONE. Main is replaced by the new entry.
  - ONE, deliver only → EMPTY.
  - TWO, deliver → ONE. Skid moves to main. No accept is possible in TWO.
  - TWO, no deliver → TWO. Outputs are held stable.
- Flush has priority over all other events. At that edge:
  - all entries are cleared and the state goes to EMPTY,
  - any accept or deliver in the same cycle is discarded,
  - out_instruction becomes NOP_INSTR and out_address becomes 0.
- When out_valid=0, out_instruction=NOP_INSTR and out_address is held at its last value. Decode may treat the pair as a bubble.

## Timing

- Reset (asynchronous, immediate): out_valid=0, out_instruction=NOP_INSTR, out_address=0, out_occupancy=0, state EMPTY, out_ready=1.
- Latency: an entry accepted at falling edge N is presented on the outputs right after edge N when the register was EMPTY, or ONE with a simultaneous deliver.
- Throughput: one instruction per cycle under continuous inp_ready.
- out_ready is registered and equals (state != TWO). It has no combinational path from inp_ready.
- Reset asserted mid-transfer drops all entries. The first accept after deassertion is allowed at the next falling edge.
- Inputs are sampled only at the falling edge. Glitches between edges have no effect.

## Configuration

- IF_ID_SKID_EN defined: behaviour exactly as above, with the two-entry skid and registered out_ready.
- IF_ID_SKID_EN undefined: single-entry register. There is no TWO state and out_occupancy never exceeds 1.
  - out_ready = !out_valid || inp_ready, combinational.
  - ONE with accept and deliver replaces main.
  - Flush and reset behaviour is unchanged.

## Structure

- Package if_id_pkg holds:
  - the state enum (IF_ID_EMPTY, IF_ID_ONE, IF_ID_TWO),
  - default width constants,
  - the default NOP encoding.
- Sub-module if_id_slot: one instruction/address/valid register with load and clear inputs. It is instantiated for main, and for skid under IF_ID_SKID_EN.
- Control (state, out_ready, slot load/clear selects) lives in if_id_stage_reg.

## Test plan

- Reset, then release with inp_valid=0 → out_valid=0, out_instruction=0000, out_ready=1, out_occupancy=0.
- Stream 0x1111@0x0000, 0x2222@0x0002, 0x3333@0x0004 with inp_ready=1 → each appears one edge later, back-to-back, out_occupancy stays 1.
- Stall: inp_ready=0 while feeding 0xAAAA then 0xBBBB → out_occupancy=2, out_ready=0, outputs hold 0xAAAA. Raise inp_ready → 0xAAAA, then 0xBBBB, each delivered once, no loss or duplication.
- Flush in TWO with inp_valid=1 on 0xCCCC → next edge out_valid=0, out_instruction=NOP_INSTR, out_occupancy=0, 0xCCCC is not accepted.
- Async reset pulsed between edges while holding two entries → outputs cleared immediately, without a clock edge.
- Build without IF_ID_SKID_EN with inp_ready=0 → out_ready drops combinationally in the same cycle, out_occupancy never reaches 2.
